rr_encoder_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among N requesters, built around the 8:3 encode function.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 35 +++
 rtl/rr_encoder_arbiter.sv | 114 +++++++++++
 tb/tb_rr_encoder_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encodings and default sizing for the round-robin arbiter
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arbState_t;

  localparam int DEF_N        = 8;
  localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder: first set Req bit at or after Ptr
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    Req,
  input  logic [IDXW-1:0] Ptr,
  output logic [IDXW-1:0] winner,
  output logic            any
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] enc;

  // Rotate so Ptr lands at bit 0; IDXW-bit index arithmetic wraps mod N because N is a power of 2.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = Req[IDXW'(i) + Ptr];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDXW'(i);
    end
  end

  assign winner = enc + Ptr;
  assign any    = |Req;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// rtl/rr_encoder_arbiter.sv - round-robin arbiter with registered one-hot grant; optional hold limit via ARB_TIMEOUT_EN
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         Req,
  output logic [N-1:0]         Gnt,
  output logic [$clog2(N)-1:0] GntIdx,
  output logic                 Good,
  output logic                 Timeout
);

  localparam int IDXW = $clog2(N);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : gBadHold
    $error("MAX_HOLD must be in 1..255");
  end

  arbState_t       state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] winner;
  logic            anyReq;
  logic [IDXW-1:0] nextPtr;

  rr_pick #(.N(N), .IDXW(IDXW)) uPick (
    .Req    (Req),
    .Ptr    (ptr),
    .winner (winner),
    .any    (anyReq)
  );

  // Released owner drops to lowest priority on the next search.
  assign nextPtr = GntIdx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] holdCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      holdCnt <= '0;
      Gnt     <= '0;
      GntIdx  <= '0;
      Good    <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            state   <= ST_BUSY;
            Gnt     <= {{(N-1){1'b0}}, 1'b1} << winner;
            GntIdx  <= winner;
            Good    <= 1'b1;
            holdCnt <= 8'd1;
          end
        end
        ST_BUSY: begin
          if (!Req[GntIdx] || holdCnt == 8'(MAX_HOLD)) begin
            state   <= ST_IDLE;
            ptr     <= nextPtr;
            Gnt     <= '0;
            GntIdx  <= '0;
            Good    <= 1'b0;
            Timeout <= Req[GntIdx];
          end else if (holdCnt != 8'hFF) begin
            holdCnt <= holdCnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      Gnt    <= '0;
      GntIdx <= '0;
      Good   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            state  <= ST_BUSY;
            Gnt    <= {{(N-1){1'b0}}, 1'b1} << winner;
            GntIdx <= winner;
            Good   <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (!Req[GntIdx]) begin
            state  <= ST_IDLE;
            ptr    <= nextPtr;
            Gnt    <= '0;
            GntIdx <= '0;
            Good   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// tb/tb_rr_encoder_arbiter.sv - directed bench with cycle-level reference model for rr_encoder_arbiter
module tb_rr_encoder_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Req;
  logic [7:0] Gnt;
  logic [2:0] GntIdx;
  logic       Good;
  logic       Timeout;

  int total = 0;
  int bad   = 0;

  rr_encoder_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .Req     (Req),
    .Gnt     (Gnt),
    .GntIdx  (GntIdx),
    .Good    (Good),
    .Timeout (Timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner number (-1 = none), search start, and hold length.
  int owner = -1;
  int ptr   = 0;
  int hold  = 0;
  bit mTimeout = 1'b0;

  always @(posedge clk) begin
    int w;
    mTimeout = 1'b0;
    if (reset) begin
      owner = -1;
      ptr   = 0;
      hold  = 0;
    end else if (owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && Req[(ptr + k) % N]) w = (ptr + k) % N;
      end
      if (w >= 0) begin
        owner = w;
        hold  = 1;
      end
    end else if (!Req[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (hold == MH) begin
        ptr      = (owner + 1) % N;
        owner    = -1;
        mTimeout = 1'b1;
      end else begin
        hold = hold + 1;
      end
`else
      hold = hold + 1;
`endif
    end
  end

  always @(negedge clk) begin
    logic [7:0] eGnt;
    logic [2:0] eIdx;
    eGnt = (owner >= 0) ? (8'd1 << owner) : 8'd0;
    eIdx = (owner >= 0) ? 3'(owner) : 3'd0;
    total++;
    if (Gnt !== eGnt || GntIdx !== eIdx || Good !== (owner >= 0) || Timeout !== mTimeout) begin
      bad++;
      $display("FAIL model t=%0t got Gnt=%h Idx=%0d Good=%b To=%b want Gnt=%h Idx=%0d Good=%b To=%b",
               $time, Gnt, GntIdx, Good, Timeout, eGnt, eIdx, owner >= 0, mTimeout);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] eGnt, input logic [2:0] eIdx,
                     input logic eGood, input logic eTo);
    total++;
    if (Gnt !== eGnt || GntIdx !== eIdx || Good !== eGood || Timeout !== eTo) begin
      bad++;
      $display("FAIL %s got Gnt=%h Idx=%0d Good=%b To=%b want Gnt=%h Idx=%0d Good=%b To=%b",
               name, Gnt, GntIdx, Good, Timeout, eGnt, eIdx, eGood, eTo);
    end
  endtask

  initial begin
    int o;
    reset = 1'b1;
    Req   = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    step(1);
    chk("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    Req = 8'h00;
    step(1);
    chk("release0", 8'h00, 3'd0, 1'b0, 1'b0);
    Req = 8'h08;
    step(1);
    chk("grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    Req = 8'h00;
    step(1);
    chk("release3", 8'h00, 3'd0, 1'b0, 1'b0);
    Req = 8'hFF;
    step(1);
    chk("ptr_is_4", 8'h10, 3'd4, 1'b1, 1'b0);

    reset = 1'b1;
    Req   = 8'h00;
    step(1);
    reset = 1'b0;
    Req   = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      o = g % 8;
      step(1);
      chk("rr_grant", 8'd1 << o, 3'(o), 1'b1, 1'b0);
      step(1);
      chk("rr_hold", 8'd1 << o, 3'(o), 1'b1, 1'b0);
      Req = 8'hFF & ~(8'd1 << o);
      step(1);
      chk("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      Req = 8'hFF;
    end

    Req = 8'h20;
    step(1);
    chk("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    Req = 8'h00;
    step(1);
    Req = 8'h03;
    step(1);
    chk("wrap_to0", 8'h01, 3'd0, 1'b1, 1'b0);
    Req = 8'h02;
    step(1);
    chk("wrap_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    chk("then1", 8'h02, 3'd1, 1'b1, 1'b0);

    reset = 1'b1;
    Req   = 8'h00;
    step(1);
    reset = 1'b0;
    Req   = 8'h05;
    step(1);
    chk("hold_start", 8'h01, 3'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    step(3);
    chk("hold_4th", 8'h01, 3'd0, 1'b1, 1'b0);
    step(1);
    chk("timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    step(1);
    chk("after_to", 8'h04, 3'd2, 1'b1, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("hold_forever", 8'h01, 3'd0, 1'b1, 1'b0);
    end
`endif

    reset = 1'b1;
    Req   = 8'h00;
    step(1);
    reset = 1'b0;
    Req   = 8'h20;
    step(2);
    chk("busy5", 8'h20, 3'd5, 1'b1, 1'b0);
    reset = 1'b1;
    step(1);
    chk("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    chk("regrant5", 8'h20, 3'd5, 1'b1, 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    Req   = 8'hFF;
    step(1);
    chk("ptr_reset0", 8'h01, 3'd0, 1'b1, 1'b0);
    Req = 8'h00;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
